// File: rtl/xillybus_axi_wr_arbiter_if.sv
// AXI3 write-channel bundle (AW, W, B) for one master/slave link of the write arbiter.
// The master modport is the side that issues addresses and data; the slave modport accepts them.
interface xillybus_axi_wr_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [3:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [2:0]            awprot;
    logic [3:0]            awcache;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awprot, awcache,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awprot, awcache,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/xillybus_axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI3 write master port between two requesters.
// Grant is held from AW handshake through B; WLAST is regenerated from the beat count.
module xillybus_axi_wr_arbiter #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 64
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_aresetn,
    xillybus_axi_wr_arbiter_if.slave        s0,
    xillybus_axi_wr_arbiter_if.slave        s1,
    xillybus_axi_wr_arbiter_if.master       m_axi,
    output logic [1:0]                      grant,
    output logic                            wlast_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   grant_q, grant_d;
    logic         ptr_q, ptr_d;
    logic [3:0]   beat_q, beat_d;
    logic [3:0]   len_q, len_d;
    logic         wlast_err_q, wlast_err_d;

    // Granted requester's view, selected by the one-hot grant (bit 1 means s1)
    logic                              sel;
    logic                              sel_awvalid;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     sel_awaddr;
    logic [3:0]                        sel_awlen;
    logic [2:0]                        sel_awsize;
    logic [1:0]                        sel_awburst;
    logic [2:0]                        sel_awprot;
    logic [3:0]                        sel_awcache;
    logic                              sel_wvalid;
    logic [C_M_AXI_DATA_WIDTH-1:0]     sel_wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   sel_wstrb;
    logic                              sel_wlast;
    logic                              sel_bready;

    logic        gnt_awready;
    logic        gnt_wready;
    logic        gnt_bvalid;
    logic [1:0]  gnt_bresp;
    logic        last_beat;

    assign sel         = grant_q[1];
    assign sel_awvalid = sel ? s1.awvalid : s0.awvalid;
    assign sel_awaddr  = sel ? s1.awaddr  : s0.awaddr;
    assign sel_awlen   = sel ? s1.awlen   : s0.awlen;
    assign sel_awsize  = sel ? s1.awsize  : s0.awsize;
    assign sel_awburst = sel ? s1.awburst : s0.awburst;
    assign sel_awprot  = sel ? s1.awprot  : s0.awprot;
    assign sel_awcache = sel ? s1.awcache : s0.awcache;
    assign sel_wvalid  = sel ? s1.wvalid  : s0.wvalid;
    assign sel_wdata   = sel ? s1.wdata   : s0.wdata;
    assign sel_wstrb   = sel ? s1.wstrb   : s0.wstrb;
    assign sel_wlast   = sel ? s1.wlast   : s0.wlast;
    assign sel_bready  = sel ? s1.bready  : s0.bready;

    assign last_beat = (beat_q == len_q);

    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= 1'b0;
            beat_q      <= '0;
            len_q       <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        beat_d        = beat_q;
        len_d         = len_q;
        wlast_err_d   = wlast_err_q;

        m_axi.awvalid = 1'b0;
        m_axi.awaddr  = '0;
        m_axi.awlen   = '0;
        m_axi.awsize  = '0;
        m_axi.awburst = '0;
        m_axi.awprot  = '0;
        m_axi.awcache = '0;
        m_axi.wvalid  = 1'b0;
        m_axi.wdata   = '0;
        m_axi.wstrb   = '0;
        m_axi.wlast   = 1'b0;
        m_axi.bready  = 1'b0;

        gnt_awready   = 1'b0;
        gnt_wready    = 1'b0;
        gnt_bvalid    = 1'b0;
        gnt_bresp     = '0;

        case (state_q)
            ST_IDLE: begin
                if (s0.awvalid || s1.awvalid) begin
                    if (s0.awvalid && s1.awvalid) begin
                        grant_d = ptr_q ? 2'b10 : 2'b01;
                    end else if (s0.awvalid) begin
                        grant_d = 2'b01;
                    end else begin
                        grant_d = 2'b10;
                    end
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                m_axi.awvalid = sel_awvalid;
                m_axi.awaddr  = sel_awaddr;
                m_axi.awlen   = sel_awlen;
                m_axi.awsize  = sel_awsize;
                m_axi.awburst = sel_awburst;
                m_axi.awprot  = sel_awprot;
                m_axi.awcache = sel_awcache;
                gnt_awready   = m_axi.awready;
                if (sel_awvalid && m_axi.awready) begin
                    len_d   = sel_awlen;
                    beat_d  = '0;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                m_axi.wvalid = sel_wvalid;
                m_axi.wdata  = sel_wdata;
                m_axi.wstrb  = sel_wstrb;
                m_axi.wlast  = last_beat;
                gnt_wready   = m_axi.wready;
                if (sel_wvalid && m_axi.wready) begin
                    if (sel_wlast != last_beat) begin
                        wlast_err_d = 1'b1;
                    end
                    // Beat counter holds at len on the final beat so awlen=15 never wraps
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end

            ST_RESP: begin
                gnt_bvalid   = m_axi.bvalid;
                gnt_bresp    = m_axi.bresp;
                m_axi.bready = sel_bready;
                if (m_axi.bvalid && sel_bready) begin
                    ptr_d   = ~sel;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign s0.awready = grant_q[0] & gnt_awready;
    assign s0.wready  = grant_q[0] & gnt_wready;
    assign s0.bvalid  = grant_q[0] & gnt_bvalid;
    assign s0.bresp   = grant_q[0] ? gnt_bresp : 2'b00;

    assign s1.awready = grant_q[1] & gnt_awready;
    assign s1.wready  = grant_q[1] & gnt_wready;
    assign s1.bvalid  = grant_q[1] & gnt_bvalid;
    assign s1.bresp   = grant_q[1] ? gnt_bresp : 2'b00;

    assign grant     = grant_q;
    assign wlast_err = wlast_err_q;

endmodule
